// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_pkg
//  Description : Shared definitions for the Sym front-end. Holds the function
//                selector encoding, the piecewise-linear coefficient tables
//                and the saturation values per function.
//                Coefficients are Q4.8 and cover 16 segments of |x| in
//                [0, 4.0). Each segment is the chord between rounded samples
//                of f at k/4, so segment k evaluates exactly to f(k/4)
//                (rounded) at its left end. This makes f(0) exact.
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_pkg;

    typedef enum logic [1:0] {
        FUNC_TANH    = 2'd0,
        FUNC_SIGMOID = 2'd1,
        FUNC_SWISH   = 2'd2
    } func_e;

    localparam int COEF_W   = 16;
    localparam int PWL_SEGS = 16;

    // slope in Q.8 per raw input LSB: y = ((slope*mag + 128) >>> 8) + icpt
    localparam logic signed [COEF_W-1:0] SLOPE_ROM [0:2][0:PWL_SEGS-1] = '{
        '{16'sd252, 16'sd220, 16'sd180, 16'sd128, 16'sd88,  16'sd60,  16'sd36,  16'sd24,
          16'sd12,  16'sd12,  16'sd4,   16'sd4,   16'sd0,   16'sd0,   16'sd0,   16'sd0},
        '{16'sd64,  16'sd60,  16'sd60,  16'sd52,  16'sd48,  16'sd40,  16'sd36,  16'sd28,
          16'sd28,  16'sd20,  16'sd16,  16'sd12,  16'sd8,   16'sd8,   16'sd8,   16'sd4},
        '{16'sd144, 16'sd176, 16'sd200, 16'sd228, 16'sd248, 16'sd260, 16'sd272, 16'sd276,
          16'sd280, 16'sd280, 16'sd284, 16'sd280, 16'sd276, 16'sd276, 16'sd272, 16'sd272}
    };

    localparam logic signed [COEF_W-1:0] ICPT_ROM [0:2][0:PWL_SEGS-1] = '{
        '{16'sd0,    16'sd8,    16'sd28,   16'sd67,   16'sd107,  16'sd142,  16'sd178,  16'sd199,
          16'sd223,  16'sd223,  16'sd243,  16'sd243,  16'sd255,  16'sd255,  16'sd255,  16'sd255},
        '{16'sd128,  16'sd129,  16'sd129,  16'sd135,  16'sd139,  16'sd149,  16'sd155,  16'sd169,
          16'sd169,  16'sd187,  16'sd197,  16'sd208,  16'sd220,  16'sd220,  16'sd220,  16'sd235},
        '{16'sd0,    -16'sd8,   -16'sd20,  -16'sd41,  -16'sd61,  -16'sd76,  -16'sd94,  -16'sd101,
          -16'sd109, -16'sd109, -16'sd119, -16'sd108, -16'sd96,  -16'sd96,  -16'sd82,  -16'sd82}
    };

    // Output for |x| >= 4.0: round(256 * f(4.0))
    localparam logic signed [COEF_W-1:0] F_SAT [0:2] = '{16'sd256, 16'sd251, 16'sd1006};

    // Lowest magnitude bit that selects the segment (X_SAT is a power of two)
    function automatic int seg_lsb(input int x_sat, input int seg_bits);
        return $clog2(x_sat) - seg_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_coeff_rom.sv
`default_nettype none
// ============================================================================
//  Module      : pwl_coeff_rom
//  Description : Registered coefficient lookup for one function type.
//                One-cycle read latency; the output register only updates
//                when i_en is high so it stays aligned with the stage it feeds.
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                i_en          load enable (stage-2 load)
//                i_seg         segment index
//                o_slope       slope of selected segment, WIDTH signed
//                o_icpt        intercept of selected segment, WIDTH signed
//  Revision    : 1.0 - initial release
// ============================================================================
module pwl_coeff_rom
    import sym_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int FUNC_TYPE = 0,
    parameter int SEG_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [SEG_BITS-1:0]     i_seg,
    output logic signed [WIDTH-1:0] o_slope,
    output logic signed [WIDTH-1:0] o_icpt
);

    logic signed [WIDTH-1:0] r_slope;
    logic signed [WIDTH-1:0] r_icpt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slope <= '0;
            r_icpt  <= '0;
        end else if (i_en) begin
            r_slope <= SLOPE_ROM[FUNC_TYPE][i_seg][WIDTH-1:0];
            r_icpt  <= ICPT_ROM[FUNC_TYPE][i_seg][WIDTH-1:0];
        end
    end

    assign o_slope = r_slope;
    assign o_icpt  = r_icpt;

endmodule
`default_nettype wire

// File: rtl/sym_fold_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : sym_fold_pwl
//  Description : Front-end for Sym. Folds a signed QM.N sample into sign and
//                magnitude and evaluates f(|x|) by piecewise-linear
//                approximation. Three-stage valid/ready pipeline:
//                  S1 fold (sign, |x|, saturation flag)
//                  S2 segment select + registered coefficient read
//                  S3 multiply-add, round, clamp / saturate (output register)
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                in_valid      x_in valid
//                in_ready      stage accepts x_in this cycle
//                x_in          signed input, QM.N
//                out_valid     y_out/sign_out valid
//                out_ready     downstream accepts this cycle
//                y_out         f(|x|), non-negative, QM.N
//                sign_out      1 when x_in < 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_fold_pwl
    import sym_pkg::*;
#(
    parameter int  M         = 4,
    parameter int  N         = 8,
    parameter int  FUNC_TYPE = int'(FUNC_TANH),
    parameter int  SEG_BITS  = 4,
    parameter int  X_SAT     = 1024,
    localparam int WIDTH     = M + N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y_out,
    output logic                    sign_out
);

    localparam int c_SEG_LSB = seg_lsb(X_SAT, SEG_BITS);

    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_X_SAT    = WIDTH'(X_SAT);
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_F_SAT    = F_SAT[FUNC_TYPE][WIDTH-1:0];

    localparam logic signed [2*WIDTH-1:0] c_RND   = (2*WIDTH)'(2**(N-1));
    localparam logic signed [2*WIDTH-1:0] c_Y_MAX = (2*WIDTH)'((2**(WIDTH-1)) - 1);

    // ------------------------------------------------------------------
    // Stage enables: a stage may load when empty or when it drains into
    // the next stage in the same cycle.
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_en1, w_en2, w_en3;

    assign w_en3    = ~r_v3 | out_ready;
    assign w_en2    = ~r_v2 | w_en3;
    assign w_en1    = ~r_v1 | w_en2;
    assign in_ready = w_en1;

    // ------------------------------------------------------------------
    // S1: fold
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_mag;
    logic             r_sign1;
    logic [WIDTH-1:0] r_mag1;
    logic             r_sat1;

    // The most-negative code has no positive twin; pin it to the largest
    // positive magnitude (it saturates anyway).
    always_comb begin
        w_mag = x_in;
        if (x_in[WIDTH-1]) begin
            if (x_in == c_MOST_NEG) begin
                w_mag = c_POS_MAX;
            end else begin
                w_mag = ~x_in + c_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
            r_sat1  <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sign1 <= x_in[WIDTH-1];
                r_mag1  <= w_mag;
                r_sat1  <= (w_mag >= c_X_SAT);
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: segment select; coefficients are registered inside the ROM on
    // the same enable so they line up with the S2 data registers.
    // ------------------------------------------------------------------
    logic [SEG_BITS-1:0]     w_seg;
    logic signed [WIDTH-1:0] w_slope;
    logic signed [WIDTH-1:0] w_icpt;
    logic                    r_sign2;
    logic [WIDTH-1:0]        r_mag2;
    logic                    r_sat2;

    // Saturated magnitudes index a wrapped segment; the result is replaced
    // by F_SAT in S3 so the value read does not matter.
    assign w_seg = r_mag1[c_SEG_LSB +: SEG_BITS];

    pwl_coeff_rom #(
        .WIDTH     (WIDTH),
        .FUNC_TYPE (FUNC_TYPE),
        .SEG_BITS  (SEG_BITS)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en2),
        .i_seg   (w_seg),
        .o_slope (w_slope),
        .o_icpt  (w_icpt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_mag2  <= '0;
            r_sat2  <= 1'b0;
        end else if (w_en2) begin
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_mag2  <= r_mag1;
            r_sat2  <= r_sat1;
        end
    end

    // ------------------------------------------------------------------
    // S3: evaluate slope*mag, round half up, add intercept, clamp
    // ------------------------------------------------------------------
    logic signed [2*WIDTH-1:0] w_slope_x;
    logic signed [2*WIDTH-1:0] w_mag_x;
    logic signed [2*WIDTH-1:0] w_icpt_x;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [2*WIDTH-1:0] w_rnd;
    logic signed [2*WIDTH-1:0] w_y;
    logic [WIDTH-1:0]          w_y_clamped;

    assign w_slope_x = {{WIDTH{w_slope[WIDTH-1]}}, w_slope};
    assign w_mag_x   = {{WIDTH{1'b0}}, r_mag2};
    assign w_icpt_x  = {{WIDTH{w_icpt[WIDTH-1]}}, w_icpt};
    assign w_prod    = w_slope_x * w_mag_x;
    assign w_rnd     = (w_prod + c_RND) >>> N;
    assign w_y       = w_rnd + w_icpt_x;

    always_comb begin
        w_y_clamped = w_y[WIDTH-1:0];
        if (w_y[2*WIDTH-1]) begin
            w_y_clamped = '0;
        end else if (w_y > c_Y_MAX) begin
            w_y_clamped = c_POS_MAX;
        end
    end

    logic             r_v3_sign;
    logic [WIDTH-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3      <= 1'b0;
            r_v3_sign <= 1'b0;
            r_y       <= '0;
        end else if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_v3_sign <= r_sign2;
                r_y       <= r_sat2 ? c_F_SAT : w_y_clamped;
            end
        end
    end

    assign out_valid = r_v3;
    assign y_out     = r_y;
    assign sign_out  = r_v3_sign;

endmodule
`default_nettype wire

// File: tb/tb_sym_fold_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sym_fold_pwl
//  Description : Self-checking bench for sym_fold_pwl. Three instances (tanh,
//                sigmoid, swish) share one input/ready stream. Expected
//                outputs come from an integer PWL model over the coefficient
//                tables plus a real-valued check against the true functions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sym_fold_pwl;
    import sym_pkg::*;

    localparam int W = 12;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                out_ready;
    logic signed [W-1:0] x_in;
    logic                rdy_t, rdy_s, rdy_w;
    logic                ov_t, ov_s, ov_w;
    logic                sg_t, sg_s, sg_w;
    logic [W-1:0]        y_t, y_s, y_w;

    int n_tests = 0;
    int n_fail  = 0;

    int stim_q[$];
    int obs_t[$];
    int obs_s[$];
    int obs_w[$];
    bit obs_sg[$];
    int acc_cyc[$];
    int take_cyc[$];
    int stall_viol;
    int lockstep_err;
    int extra_out;
    bit saw_bp;
    bit timed_out;

    sym_fold_pwl #(.M(4), .N(8), .FUNC_TYPE(0), .SEG_BITS(4), .X_SAT(1024)) u_tanh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_t), .x_in(x_in),
        .out_valid(ov_t), .out_ready(out_ready), .y_out(y_t), .sign_out(sg_t));

    sym_fold_pwl #(.M(4), .N(8), .FUNC_TYPE(1), .SEG_BITS(4), .X_SAT(1024)) u_sig (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .x_in(x_in),
        .out_valid(ov_s), .out_ready(out_ready), .y_out(y_s), .sign_out(sg_s));

    sym_fold_pwl #(.M(4), .N(8), .FUNC_TYPE(2), .SEG_BITS(4), .X_SAT(1024)) u_swish (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .x_in(x_in),
        .out_valid(ov_w), .out_ready(out_ready), .y_out(y_w), .sign_out(sg_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // round(256 * f(4.0)) for tanh, sigmoid, swish
    function automatic int sat_value(input int f);
        case (f)
            0:       return 256;
            1:       return 251;
            default: return 1006;
        endcase
    endfunction

    // Golden PWL: 16 equal segments over [0, 4.0), round half up, clamp.
    function automatic int ref_pwl(input int f, input int x);
        int mag, seg, q, y;
        mag = (x < 0) ? -x : x;
        if (mag > 2047) mag = 2047;
        if (mag >= 1024) return sat_value(f);
        seg = mag / 64;
        q = int'(SLOPE_ROM[f][seg]) * mag + 128;
        if (q >= 0) q = q / 256;
        else        q = -((-q + 255) / 256);
        y = q + int'(ICPT_ROM[f][seg]);
        if (y < 0)    y = 0;
        if (y > 2047) y = 2047;
        return y;
    endfunction

    function automatic real fn_real(input int f, input real v);
        case (f)
            0:       return (1.0 - $exp(-2.0 * v)) / (1.0 + $exp(-2.0 * v));
            1:       return 1.0 / (1.0 + $exp(-v));
            default: return v / (1.0 + $exp(-v));
        endcase
    endfunction

    // Drives stim_q through the shared stream and records what comes out.
    // mode 0: out_ready always 1; mode 1: pattern 1,0,0; mode 2: random.
    task automatic run_stream(input int mode);
        int idx, cyc;
        bit prev_stall;
        logic [W-1:0] prev_y;
        logic prev_sg;
        idx = 0; cyc = 0; prev_stall = 0; prev_y = '0; prev_sg = 1'b0;
        obs_t.delete(); obs_s.delete(); obs_w.delete(); obs_sg.delete();
        acc_cyc.delete(); take_cyc.delete();
        stall_viol = 0; lockstep_err = 0; extra_out = 0; saw_bp = 0; timed_out = 0;
        while ((idx < stim_q.size() || obs_t.size() < stim_q.size()) && cyc < 2000) begin
            @(negedge clk);
            if (idx < stim_q.size()) begin
                in_valid = 1'b1;
                x_in     = W'(stim_q[idx]);
            end else begin
                in_valid = 1'b0;
                x_in     = '0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall && (ov_t !== 1'b1 || y_t !== prev_y || sg_t !== prev_sg))
                stall_viol++;
            if (rdy_s !== rdy_t || rdy_w !== rdy_t || ov_s !== ov_t || ov_w !== ov_t)
                lockstep_err++;
            if (ov_t && (sg_s !== sg_t || sg_w !== sg_t))
                lockstep_err++;
            if (in_valid && !rdy_t)
                saw_bp = 1;
            if (ov_t && out_ready) begin
                obs_t.push_back(int'(y_t));
                obs_s.push_back(int'(y_s));
                obs_w.push_back(int'(y_w));
                obs_sg.push_back(sg_t);
                take_cyc.push_back(cyc);
            end
            if (in_valid && rdy_t) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            prev_stall = ov_t && !out_ready;
            prev_y     = y_t;
            prev_sg    = sg_t;
            cyc++;
        end
        if (cyc >= 2000) timed_out = 1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            if (ov_t) extra_out++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; x_in = 12'sd300; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (ov_t !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov_t); end
        n_tests++;
        if (y_t !== '0) begin n_fail++; $display("FAIL reset_y_out: got %0d expected 0", y_t); end
        n_tests++;
        if (sg_t !== 1'b0) begin n_fail++; $display("FAIL reset_sign_out: got %b expected 0", sg_t); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++;
        if (rdy_t !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", rdy_t); end
    endtask

    task automatic test_zero();
        stim_q = '{0};
        run_stream(0);
        n_tests++;
        if (obs_t.size() != 1 || timed_out) begin
            n_fail++; $display("FAIL zero_count: got %0d expected 1", obs_t.size());
        end else begin
            n_tests++;
            if (take_cyc[0] - acc_cyc[0] != 3) begin
                n_fail++; $display("FAIL latency: got %0d expected 3", take_cyc[0] - acc_cyc[0]);
            end
            n_tests++;
            if (obs_t[0] != 0 || obs_sg[0] != 0) begin
                n_fail++; $display("FAIL zero_tanh: got y=%0d s=%0d expected y=0 s=0", obs_t[0], obs_sg[0]);
            end
            n_tests++;
            if (obs_s[0] != 128) begin n_fail++; $display("FAIL zero_sigmoid: got %0d expected 128", obs_s[0]); end
            n_tests++;
            if (obs_w[0] != 0) begin n_fail++; $display("FAIL zero_swish: got %0d expected 0", obs_w[0]); end
        end
    endtask

    task automatic test_boundary();
        stim_q = '{-2048, 1024, 1023, -1023, -1024, 2047};
        run_stream(0);
        n_tests++;
        if (obs_t.size() != stim_q.size()) begin
            n_fail++; $display("FAIL bound_count: got %0d expected %0d", obs_t.size(), stim_q.size());
        end else begin
            n_tests++;
            if (obs_t[0] != 256 || obs_sg[0] != 1) begin
                n_fail++; $display("FAIL bound_most_neg: got y=%0d s=%0d expected y=256 s=1", obs_t[0], obs_sg[0]);
            end
            n_tests++;
            if (obs_t[1] != 256 || obs_sg[1] != 0) begin
                n_fail++; $display("FAIL bound_xsat: got y=%0d s=%0d expected y=256 s=0", obs_t[1], obs_sg[1]);
            end
            n_tests++;
            if (obs_t[2] != ref_pwl(0, 1023)) begin
                n_fail++; $display("FAIL bound_last_seg: got %0d expected %0d", obs_t[2], ref_pwl(0, 1023));
            end
            n_tests++;
            if (obs_t[2] >= 256) begin n_fail++; $display("FAIL bound_below_sat: got %0d expected < 256", obs_t[2]); end
            for (int i = 3; i < stim_q.size(); i++) begin
                n_tests++;
                if (obs_t[i] != ref_pwl(0, stim_q[i]) || obs_s[i] != ref_pwl(1, stim_q[i]) ||
                    obs_w[i] != ref_pwl(2, stim_q[i])) begin
                    n_fail++;
                    $display("FAIL bound_x%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", stim_q[i],
                             obs_t[i], obs_s[i], obs_w[i],
                             ref_pwl(0, stim_q[i]), ref_pwl(1, stim_q[i]), ref_pwl(2, stim_q[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_sg [5] = '{0, 1, 0, 0, 1};
        stim_q = '{50, -100, 77, 123, -88};
        run_stream(0);
        n_tests++;
        if (obs_t.size() != 5 || extra_out != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d extra %0d expected 5 extra 0", obs_t.size(), extra_out);
        end else begin
            n_tests++;
            if (take_cyc[4] - take_cyc[0] != 4 || saw_bp) begin
                n_fail++; $display("FAIL b2b_spacing: got span %0d bp %0d expected 4 bp 0",
                                   take_cyc[4] - take_cyc[0], saw_bp);
            end
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (obs_sg[i] != exp_sg[i] || obs_t[i] != ref_pwl(0, stim_q[i]) ||
                    obs_s[i] != ref_pwl(1, stim_q[i]) || obs_w[i] != ref_pwl(2, stim_q[i])) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got s=%0d y=%0d/%0d/%0d expected s=%0d y=%0d/%0d/%0d", i,
                             obs_sg[i], obs_t[i], obs_s[i], obs_w[i], exp_sg[i],
                             ref_pwl(0, stim_q[i]), ref_pwl(1, stim_q[i]), ref_pwl(2, stim_q[i]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        stim_q = '{50, -100, 77, 123, -88};
        run_stream(1);
        n_tests++;
        if (obs_t.size() != 5 || extra_out != 0 || timed_out) begin
            n_fail++; $display("FAIL bp_count: got %0d extra %0d expected 5 extra 0", obs_t.size(), extra_out);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (obs_sg[i] != (stim_q[i] < 0) || obs_t[i] != ref_pwl(0, stim_q[i])) begin
                    n_fail++; $display("FAIL bp_%0d: got s=%0d y=%0d expected s=%0d y=%0d", i,
                                       obs_sg[i], obs_t[i], stim_q[i] < 0, ref_pwl(0, stim_q[i]));
                end
            end
        end
        n_tests++;
        if (!saw_bp) begin n_fail++; $display("FAIL bp_in_ready_drop: got 0 expected 1"); end
        n_tests++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_viol); end
    endtask

    task automatic test_random();
        int x, mag, errs, real_errs;
        real e;
        stim_q.delete();
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0) x = int'($urandom_range(0, 4095)) - 2048;
            else            x = int'($urandom_range(0, 2047)) - 1024;
            stim_q.push_back(x);
        end
        run_stream(2);
        n_tests++;
        if (obs_t.size() != stim_q.size() || extra_out != 0 || timed_out) begin
            n_fail++; $display("FAIL rand_count: got %0d extra %0d expected %0d extra 0",
                               obs_t.size(), extra_out, stim_q.size());
        end else begin
            errs = 0; real_errs = 0;
            for (int i = 0; i < stim_q.size(); i++) begin
                n_tests++;
                if (obs_sg[i] != (stim_q[i] < 0) || obs_t[i] != ref_pwl(0, stim_q[i]) ||
                    obs_s[i] != ref_pwl(1, stim_q[i]) || obs_w[i] != ref_pwl(2, stim_q[i])) begin
                    n_fail++;
                    $display("FAIL rand_x%0d: got s=%0d y=%0d/%0d/%0d expected s=%0d y=%0d/%0d/%0d",
                             stim_q[i], obs_sg[i], obs_t[i], obs_s[i], obs_w[i], stim_q[i] < 0,
                             ref_pwl(0, stim_q[i]), ref_pwl(1, stim_q[i]), ref_pwl(2, stim_q[i]));
                end
                mag = (stim_q[i] < 0) ? -stim_q[i] : stim_q[i];
                if (mag < 1024) begin
                    e = real'(obs_t[i]) - 256.0 * fn_real(0, real'(mag) / 256.0);
                    if (e > 3.0 || e < -3.0) real_errs++;
                    e = real'(obs_s[i]) - 256.0 * fn_real(1, real'(mag) / 256.0);
                    if (e > 3.0 || e < -3.0) real_errs++;
                    e = real'(obs_w[i]) - 256.0 * fn_real(2, real'(mag) / 256.0);
                    if (e > 3.0 || e < -3.0) real_errs++;
                end
            end
            n_tests++;
            if (real_errs != 0) begin
                n_fail++; $display("FAIL rand_vs_true_fn: got %0d outliers expected 0", real_errs);
            end
        end
        n_tests++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL rand_stable: got %0d changes expected 0", stall_viol); end
        n_tests++;
        if (lockstep_err != 0) begin n_fail++; $display("FAIL rand_lockstep: got %0d expected 0", lockstep_err); end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in     = W'(100 + 200 * i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (ov_t !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b expected 1", ov_t); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (ov_t !== 1'b0 || y_t !== '0) begin
            n_fail++; $display("FAIL mid_async_clear: got v=%b y=%0d expected v=0 y=0", ov_t, y_t);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (ov_t) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_stale: got %0d outputs expected 0", seen); end
        stim_q = '{-300};
        run_stream(0);
        n_tests++;
        if (obs_t.size() != 1 || extra_out != 0) begin
            n_fail++; $display("FAIL mid_new_count: got %0d extra %0d expected 1 extra 0", obs_t.size(), extra_out);
        end else begin
            n_tests++;
            if (obs_t[0] != ref_pwl(0, -300) || obs_sg[0] != 1) begin
                n_fail++; $display("FAIL mid_new_value: got y=%0d s=%0d expected y=%0d s=1",
                                   obs_t[0], obs_sg[0], ref_pwl(0, -300));
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
        test_reset();
        test_zero();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
